// File: rtl/p2s_stream_tx.sv
// p2s_stream_tx: SPI-slave transmit with word FIFO, oversampled sck/cs, underrun flag.
// Define P2S_PARITY_EN to append an even-parity bit after each word.
module p2s_stream_tx #(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sck,
    input  logic                          cs,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          clr_underrun,
    output logic                          miso,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef P2S_PARITY_EN
    localparam int WB = DATA_W + 1;
`else
    localparam int WB = DATA_W;
`endif
    localparam int CW = $clog2(WB);
    localparam bit MSB = MSB_FIRST != 0;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sck_q, cs_q;
    logic              sck_fall_q, cs_fall_q, cs_rise_q;
    logic [WB-1:0]     sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              und_q, und_d;
    logic [AW:0]       wp_q, rp_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] head;
    logic [WB-1:0]     word;
    logic              load, push, pop, empty;

    assign fifo_level = wp_q - rp_q;
    assign empty      = fifo_level == '0;
    assign in_ready   = ~fifo_level[AW];
    assign push       = in_valid & in_ready;
    assign pop        = load & ~empty;
    assign head       = empty ? '0 : mem_q[rp_q[AW-1:0]];
`ifdef P2S_PARITY_EN
    assign word = MSB ? {head, ^head} : {^head, head};
`else
    assign word = head;
`endif
    assign busy     = state_q == SHIFT;
    assign miso     = busy & (MSB ? sr_q[WB-1] : sr_q[0]);
    assign underrun = und_q;

    // cs resets to the deasserted level so reset release never looks like a frame start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_q      <= '0;
            cs_q       <= '1;
            sck_fall_q <= 1'b0;
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            und_q      <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
        end else begin
            sck_q      <= {sck_q[1:0], sck};
            cs_q       <= {cs_q[1:0], cs};
            sck_fall_q <= sck_q[2] & ~sck_q[1];
            cs_fall_q  <= cs_q[2] & ~cs_q[1];
            cs_rise_q  <= ~cs_q[2] & cs_q[1];
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            und_q      <= und_d;
            wp_q       <= push ? wp_q + 1'b1 : wp_q;
            rp_q       <= pop ? rp_q + 1'b1 : rp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[AW-1:0]] <= in_data;
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall_q) begin
                state_d = SHIFT;
                load    = 1'b1;
            end
        end else if (cs_rise_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (sck_fall_q) begin
            load  = cnt_q == CW'(WB - 1);
            cnt_d = load ? '0 : cnt_q + CW'(1);
            sr_d  = MSB ? sr_q << 1 : sr_q >> 1;
        end
        if (load) sr_d = word;
        und_d = (load & empty) | (und_q & ~clr_underrun);
    end
endmodule

// File: tb/tb_p2s_stream_tx.sv
// tb_p2s_stream_tx: randomized frames checked against a word-queue model of the transmitter.
module tb_p2s_stream_tx;
    localparam int DW    = 14;
    localparam int DEPTH = 4;
`ifdef P2S_PARITY_EN
    localparam int WB = DW + 1;
`else
    localparam int WB = DW;
`endif

    logic          clk = 1'b0, rstn = 1'b0, sck = 1'b0, cs = 1'b1;
    logic          in_valid = 1'b0, clr_underrun = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, miso, busy, underrun;
    logic [2:0]    fifo_level;

    int tests = 0, fails = 0;
    logic [DW-1:0] q[$];
    logic          und_m = 1'b0;

    p2s_stream_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) dut (
        .clk(clk), .rstn(rstn), .sck(sck), .cs(cs), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .clr_underrun(clr_underrun),
        .miso(miso), .busy(busy), .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        if (q.size() < DEPTH) q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clr();
        clr_underrun = 1'b1;
        tick(1);
        clr_underrun = 1'b0;
        und_m = 1'b0;
    endtask

    // bit j of a transmitted word, in wire order
    function automatic logic tx_bit(input logic [DW-1:0] w, input int j);
        if (j >= DW) return ^w;
        return w[DW-1-j];
    endfunction

    task automatic model_frame(input int n, output logic [255:0] e);
        logic [DW-1:0] ws[$];
        e = '0;
        for (int k = 0; k <= n / WB; k++) begin
            if (q.size() > 0) ws.push_back(q.pop_front());
            else begin
                ws.push_back('0);
                und_m = 1'b1;
            end
        end
        for (int i = 0; i < n; i++) e[i] = tx_bit(ws[i / WB], i % WB);
    endtask

    task automatic frame(input int n, output logic [255:0] r, output logic b);
        r  = '0;
        cs = 1'b0;
        tick(6);
        b = busy;
        for (int i = 0; i < n; i++) begin
            r[i] = miso;
            sck  = 1'b1;
            tick(4);
            sck  = 1'b0;
            tick(4);
        end
        tick(2);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic check_frame(input string name, input int n);
        logic [255:0] r, e;
        logic b;
        model_frame(n, e);
        frame(n, r, b);
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL %s bits: got %h expected %h", name, r, e);
        end
        tests++;
        if (b !== 1'b1) begin
            fails++;
            $display("FAIL %s busy: got %b expected 1", name, b);
        end
        tests++;
        if (fifo_level !== 3'(q.size())) begin
            fails++;
            $display("FAIL %s level: got %0d expected %0d", name, fifo_level, q.size());
        end
        tests++;
        if (underrun !== und_m) begin
            fails++;
            $display("FAIL %s underrun: got %b expected %b", name, underrun, und_m);
        end
        tests++;
        if ({busy, miso} !== 2'b00) begin
            fails++;
            $display("FAIL %s idle: got busy=%b miso=%b expected 0 0", name, busy, miso);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sck = ~sck;
            tick(2);
        end
        tests++;
        if ({miso, busy, in_ready, fifo_level, underrun} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset: got miso=%b busy=%b in_ready=%b level=%0d underrun=%b expected 0 0 1 0 0",
                     miso, busy, in_ready, fifo_level, underrun);
        end
        sck  = 1'b0;
        rstn = 1'b1;
        tick(4);
    endtask

    task automatic test_single();
        logic [255:0] r, e;
        logic b;
        push(14'h2A5C);
        tests++;
        if (fifo_level !== 3'd1) begin
            fails++;
            $display("FAIL single level_after_push: got %0d expected 1", fifo_level);
        end
        model_frame(WB, e);
        frame(WB, r, b);
        tests++;
        if (r[13:0] !== 14'b00111010010101) begin
            fails++;
            $display("FAIL single bits: got %b expected 00111010010101 (lsb first received)", r[13:0]);
        end
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL single model: got %h expected %h", r, e);
        end
        tests++;
        if (fifo_level !== 3'd0 || underrun !== und_m) begin
            fails++;
            $display("FAIL single post: got level=%0d underrun=%b expected 0 %b", fifo_level, underrun, und_m);
        end
        clr();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        check_frame("back_to_back", 3 * WB);
        clr();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH + 1; i++) push(DW'($urandom));
        tests++;
        if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin
            fails++;
            $display("FAIL full: got in_ready=%b level=%0d expected 0 4", in_ready, fifo_level);
        end
        check_frame("full_drain", DEPTH * WB);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full in_ready_after_drain: got %b expected 1", in_ready);
        end
        clr();
    endtask

    task automatic test_underrun();
        check_frame("underrun", WB);
        clr();
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_clear: got %b expected 0", underrun);
        end
    endtask

    task automatic test_abort();
        push(DW'($urandom));
        push(DW'($urandom));
        check_frame("abort_partial", 5);
        check_frame("abort_next", WB);
        clr();
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int np = $urandom_range(0, 3);
            for (int i = 0; i < np; i++) push(DW'($urandom));
            check_frame("random", $urandom_range(1, 3 * WB));
            if ($urandom_range(0, 1) == 1) clr();
        end
    endtask

    task automatic test_reset_mid_frame();
        push(DW'($urandom));
        push(DW'($urandom));
        cs = 1'b0;
        tick(6);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
        rstn = 1'b0;
        cs   = 1'b1;
        #1;
        tests++;
        if ({miso, busy, in_ready, fifo_level, underrun} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_frame: got miso=%b busy=%b in_ready=%b level=%0d underrun=%b expected 0 0 1 0 0",
                     miso, busy, in_ready, fifo_level, underrun);
        end
        q.delete();
        und_m = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(4);
        push(DW'($urandom));
        check_frame("after_reset", WB);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_underrun();
        test_abort();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/p2s_stream_tx.md
# p2s_stream_tx

Parametrised SPI-slave transmit block for the adaptive-filter serial readout path. Core logic pushes DATA_W-bit words (filter outputs or coefficients) into a small FIFO. The block serialises them onto miso while an external master drives sck with cs held low, streaming back-to-back words within one frame. Unlike the single-register shifter it replaces, it runs entirely on the system clock and oversamples sck/cs. It also buffers words, supports either bit order, and flags underruns.

## Interface
- DATA_W, 14, word width in bits (2..32)
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
- clk  input  1  system clock; all state on rising edge
- rstn  input  1  asynchronous active-low reset
- sck  input  1  SPI clock from master, asynchronous to clk
- cs  input  1  SPI chip select, active low, asynchronous to clk
- in_data  input  DATA_W  parallel word to transmit
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept a word (= not full)
- clr_underrun  input  1  synchronous clear of underrun flag
- miso  output  1  serial data to master
- busy  output  1  frame active (synchronised cs low)
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words held
- underrun  output  1  sticky: word loaded from empty FIFO

## Operation
- sck and cs each pass through a 2-flop synchroniser, then a history flop. Events are derived from the synchronised signals: cs_fall, cs_rise, sck_fall.
- FIFO: push when in_valid && in_ready. Pop happens only on a word load. Push and pop in the same cycle leave the level unchanged. A push while full is not accepted, even if a pop occurs that cycle. There is no bypass, so a word pushed in the same cycle as a load from an empty FIFO is not used by that load.
- States:
  - IDLE: miso=0, busy=0.
  - On cs_fall: go to SHIFT and load the shift register.
  - SHIFT: on each sck_fall, shift by one and increment bit_cnt.
  - When bit_cnt reaches WORD_BITS-1 and sck_fall occurs, load the next word (continuous stream) and clear bit_cnt.
  - cs_rise in any SHIFT cycle: go to IDLE. The partial word is discarded, not re-queued. cs_rise has priority over a simultaneous sck_fall.
- Load: if FIFO is non-empty, pop the head. If empty, load all-zeros and set underrun. underrun stays set until clr_underrun; a set and a clear in the same cycle leave it set.
- miso = shift-register bit [WORD_BITS-1] when MSB_FIRST, else bit [0], forced 0 in IDLE.
- WORD_BITS = DATA_W, or DATA_W+1 with parity (see Configuration).
- sck edges while cs is high are ignored.

## Timing
- Reset values: miso=0, busy=0, in_ready=1, fifo_level=0, underrun=0, state IDLE, bit_cnt=0.
- Latency from a pin edge to the event: 3 clk (2 synchroniser + 1 edge detect). miso changes on the clk edge after the event is registered, i.e. at most 4 clk after the pin edge.
- The first bit is valid 4 clk after cs falls. Each subsequent bit is valid 4 clk after sck falls. The master samples on the rising edge of sck (mode 0).
- Required clk ≥ 8 × f_sck, with sck high and low phases each ≥ 4 clk.
- in_ready deasserts in the cycle after the push that fills the FIFO. fifo_level updates one cycle after a push or pop.
- Asserting rstn mid-frame immediately forces the reset values. The FIFO contents are lost.

## Configuration
- P2S_PARITY_EN defined: WORD_BITS = DATA_W+1. An even-parity bit (XOR of the word) is shifted after the data bits. An underrun word therefore carries parity 0.
- P2S_PARITY_EN undefined: WORD_BITS = DATA_W and no parity logic exists.

## Test plan
- Reset: hold rstn=0 with sck toggling -> miso=0, in_ready=1, fifo_level=0, underrun=0.
- Push 14'h2A5C, DATA_W=14, MSB_FIRST=1, then a 14-clock frame at clk/8 -> master captures 10_1010_0101_1100 and fifo_level returns to 0.
- Push 3 words, then one 42-sck frame -> all three words are received back-to-back in order, with no gap bits.
- Push FIFO_DEPTH+1 words with no frame -> in_ready=0 after 4 words, the 5th is not accepted, fifo_level=4.
- Frame with empty FIFO -> 14 zero bits received and underrun=1. clr_underrun pulse -> underrun=0.
- Raise cs after 5 bits of word A (queue A,B), then start a new frame -> word B is received intact and A is dropped. With P2S_PARITY_EN, word 14'h0001 -> 15 bits ending in parity 1.
